// File: rtl/fb_pkg.sv
// Shared geometry constants, FSM state encoding and address helpers for the camera frame-buffer writer.
package fb_pkg;

  localparam int CAM_W     = 320;
  localparam int CAM_H     = 240;
  localparam int FB_DEPTH  = 76800;
  localparam int FB_ADDR_W = 17;
  localparam int PIX_W     = 16;
  localparam int HC_W      = 9;
  localparam int VC_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    DONE
  } fb_state_e;

  function automatic logic [FB_ADDR_W-1:0] raster_addr(input logic [HC_W-1:0] h,
                                                       input logic [VC_W-1:0] v);
    return FB_ADDR_W'(v) * FB_ADDR_W'(CAM_W) + FB_ADDR_W'(h);
  endfunction

  // Transposed layout: 240 wide by 320 tall, row 0 of the camera lands in the last column.
  function automatic logic [FB_ADDR_W-1:0] rotate_addr(input logic [HC_W-1:0] h,
                                                       input logic [VC_W-1:0] v);
    return FB_ADDR_W'(h) * FB_ADDR_W'(CAM_H) + FB_ADDR_W'(CAM_H - 1) - FB_ADDR_W'(v);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Two-stage write pipeline: stage 1 registers the accepted pixel, stage 2 registers address/data/enable.
// Address layout is raster by default, transposed when FB_ROTATE_EN is defined.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 wr_valid_i,
  input  logic [HC_W-1:0]      hcount_i,
  input  logic [VC_W-1:0]      vcount_i,
  input  logic [PIX_W-1:0]     pixel_i,
  input  logic                 commit_i,
  output logic [FB_ADDR_W-1:0] addr_o,
  output logic [PIX_W-1:0]     pixel_o,
  output logic                 we_o,
  output logic                 commit_o
);

  logic              s1_valid_q;
  logic [HC_W-1:0]   s1_h_q;
  logic [VC_W-1:0]   s1_v_q;
  logic [PIX_W-1:0]  s1_pix_q;
  logic              s1_commit_q;
  logic [FB_ADDR_W-1:0] s1_addr;

  logic [FB_ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]     pix_q;
  logic                 we_q;
  logic                 commit_q;

`ifdef FB_ROTATE_EN
  assign s1_addr = rotate_addr(s1_h_q, s1_v_q);
`else
  assign s1_addr = raster_addr(s1_h_q, s1_v_q);
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid_q  <= 1'b0;
      s1_h_q      <= '0;
      s1_v_q      <= '0;
      s1_pix_q    <= '0;
      s1_commit_q <= 1'b0;
    end else begin
      s1_valid_q  <= wr_valid_i;
      s1_commit_q <= commit_i;
      if (wr_valid_i) begin
        s1_h_q   <= hcount_i;
        s1_v_q   <= vcount_i;
        s1_pix_q <= pixel_i;
      end
    end
  end

  // Address and data only move on a write so the memory port sees stable values between writes.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_q   <= '0;
      pix_q    <= '0;
      we_q     <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      we_q     <= s1_valid_q;
      commit_q <= s1_commit_q;
      if (s1_valid_q) begin
        addr_q <= s1_addr;
        pix_q  <= s1_pix_q;
      end
    end
  end

  assign addr_o   = addr_q;
  assign pixel_o  = pix_q;
  assign we_o     = we_q;
  assign commit_o = commit_q;

endmodule

// File: rtl/frame_buff_writer.sv
// Camera-to-frame-buffer writer: frame sync FSM and write counter; optional FB_ROTATE_EN transposes the layout.
// States: IDLE disabled | WAIT_SOF await pixel (0,0) | CAPTURE writing frame | DONE one-cycle commit.
module frame_buff_writer
  import fb_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 capture_en_in,
  input  logic                 pixel_valid_in,
  input  logic [HC_W-1:0]      cam_hcount_in,
  input  logic [VC_W-1:0]      cam_vcount_in,
  input  logic [PIX_W-1:0]     pixel_in,
  input  logic                 frame_done_in,
  output logic [FB_ADDR_W-1:0] addr_out,
  output logic [PIX_W-1:0]     pixel_out,
  output logic                 we_out,
  output logic                 frame_valid_out,
  output logic                 short_frame_out,
  output logic                 busy_out
);

  fb_state_e            state_q, state_d;
  logic [FB_ADDR_W-1:0] cnt_q, cnt_d;
  logic                 short_q, short_d;
  logic                 in_range, sof, accept, commit;

  assign in_range = pixel_valid_in
                    && (cam_hcount_in < HC_W'(CAM_W))
                    && (cam_vcount_in < VC_W'(CAM_H));
  assign sof      = in_range && (cam_hcount_in == '0) && (cam_vcount_in == '0);
  assign commit   = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = short_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (capture_en_in) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!capture_en_in) begin
          state_d = IDLE;
        end else if (sof) begin
          accept  = 1'b1;
          cnt_d   = FB_ADDR_W'(1);
          short_d = 1'b0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (in_range) begin
          accept = 1'b1;
          if (cnt_q < FB_ADDR_W'(FB_DEPTH)) cnt_d = cnt_q + FB_ADDR_W'(1);
        end
        // A fresh (0,0) without frame_done closes the old frame as short and restarts in place.
        if (sof) begin
          cnt_d   = FB_ADDR_W'(1);
          short_d = 1'b1;
        end else if (frame_done_in) begin
          state_d = DONE;
          if (cnt_d < FB_ADDR_W'(FB_DEPTH)) short_d = 1'b1;
        end
      end
      DONE: begin
        state_d = capture_en_in ? WAIT_SOF : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
    end
  end

  // The commit pulse rides the same pipeline so frame_valid_out lands after the last write.
  fb_addr_gen u_addr_gen (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .wr_valid_i (accept),
    .hcount_i   (cam_hcount_in),
    .vcount_i   (cam_vcount_in),
    .pixel_i    (pixel_in),
    .commit_i   (commit),
    .addr_o     (addr_out),
    .pixel_o    (pixel_out),
    .we_o       (we_out),
    .commit_o   (frame_valid_out)
  );

  assign short_frame_out = short_q;
  assign busy_out        = (state_q == CAPTURE);

endmodule

// File: tb/tb_frame_buff_writer.sv
// Scoreboard bench for frame_buff_writer: stimulus pushes expected writes/commits, a negedge monitor checks them.
module tb_frame_buff_writer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        capture_en_in;
  logic        pixel_valid_in;
  logic [8:0]  cam_hcount_in;
  logic [7:0]  cam_vcount_in;
  logic [15:0] pixel_in;
  logic        frame_done_in;
  logic [16:0] addr_out;
  logic [15:0] pixel_out;
  logic        we_out;
  logic        frame_valid_out;
  logic        short_frame_out;
  logic        busy_out;

  frame_buff_writer dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .capture_en_in   (capture_en_in),
    .pixel_valid_in  (pixel_valid_in),
    .cam_hcount_in   (cam_hcount_in),
    .cam_vcount_in   (cam_vcount_in),
    .pixel_in        (pixel_in),
    .frame_done_in   (frame_done_in),
    .addr_out        (addr_out),
    .pixel_out       (pixel_out),
    .we_out          (we_out),
    .frame_valid_out (frame_valid_out),
    .short_frame_out (short_frame_out),
    .busy_out        (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { logic [16:0] addr; logic [15:0] pix; int cyc; } wr_t;
  typedef struct { logic short_f; int cyc; } fv_t;
  wr_t wr_q[$];
  fv_t fv_q[$];

  int n_total = 0;
  int n_pass  = 0;
  logic [16:0] hold_addr = '0;
  logic [15:0] hold_pix  = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_evt(input string name, input longint act, input longint exp);
    n_total++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int exp_addr(input int h, input int v);
`ifdef FB_ROTATE_EN
    return h * 240 + (239 - v);
`else
    return v * 320 + h;
`endif
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      hold_addr = '0;
      hold_pix  = '0;
    end else begin
      if (we_out) begin
        if (wr_q.size() == 0) begin
          fail_evt("unexpected_we_addr", longint'(addr_out), -1);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", longint'(addr_out), longint'(e.addr));
          check("wr_pix", longint'(pixel_out), longint'(e.pix));
          check("wr_latency_cycle", longint'(cyc), longint'(e.cyc));
          hold_addr = e.addr;
          hold_pix  = e.pix;
        end
      end else begin
        check("hold_addr", longint'(addr_out), longint'(hold_addr));
        check("hold_pix", longint'(pixel_out), longint'(hold_pix));
        if (wr_q.size() != 0 && wr_q[0].cyc <= cyc) begin
          wr_t m;
          m = wr_q.pop_front();
          fail_evt("missing_we_addr", -1, longint'(m.addr));
        end
      end
      if (frame_valid_out) begin
        if (fv_q.size() == 0) begin
          fail_evt("unexpected_frame_valid", 1, 0);
        end else begin
          fv_t f;
          f = fv_q.pop_front();
          check("frame_valid_cycle", longint'(cyc), longint'(f.cyc));
          check("short_at_commit", longint'(short_frame_out), longint'(f.short_f));
        end
      end else if (fv_q.size() != 0 && fv_q[0].cyc <= cyc) begin
        fv_t g;
        g = fv_q.pop_front();
        fail_evt("missing_frame_valid_cycle", -1, longint'(g.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic [15:0] p, input logic exp_wr);
    pixel_valid_in = 1'b1;
    cam_hcount_in  = 9'(h);
    cam_vcount_in  = 8'(v);
    pixel_in       = p;
    if (exp_wr) wr_q.push_back('{addr: 17'(exp_addr(h, v)), pix: p, cyc: cyc + 2});
  endtask

  task automatic drive_at(input int h, input int v, input logic [15:0] p, input int addr);
    pixel_valid_in = 1'b1;
    cam_hcount_in  = 9'(h);
    cam_vcount_in  = 8'(v);
    pixel_in       = p;
    wr_q.push_back('{addr: 17'(addr), pix: p, cyc: cyc + 2});
  endtask

  task automatic done_push(input logic short_f);
    frame_done_in = 1'b1;
    fv_q.push_back('{short_f: short_f, cyc: cyc + 3});
  endtask

  task automatic quiet(input int n);
    pixel_valid_in = 1'b0;
    frame_done_in  = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((wr_q.size() != 0 || fv_q.size() != 0) && k < 20) begin
      tick();
      k++;
    end
    if (wr_q.size() != 0 || fv_q.size() != 0)
      fail_evt("drain_timeout_pending", longint'(wr_q.size() + fv_q.size()), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_in       = 1'b0;
    capture_en_in  = 1'b0;
    pixel_valid_in = 1'b0;
    cam_hcount_in  = '0;
    cam_vcount_in  = '0;
    pixel_in       = '0;
    frame_done_in  = 1'b0;
    repeat (3) tick();

    check("rst_addr", longint'(addr_out), 0);
    check("rst_pix", longint'(pixel_out), 0);
    check("rst_we", longint'(we_out), 0);
    check("rst_frame_valid", longint'(frame_valid_out), 0);
    check("rst_short", longint'(short_frame_out), 0);
    check("rst_busy", longint'(busy_out), 0);
    rst_n_in = 1'b1;
    quiet(2);

    // Enable rises mid-frame: nothing may be written until the next (0,0).
    drive(98, 50, 16'h1111, 1'b0); tick();
    drive(99, 50, 16'h2222, 1'b0); tick();
    capture_en_in = 1'b1;
    for (int h = 100; h < 320; h++) begin drive(h, 50, 16'(h), 1'b0); tick(); end
    for (int h = 0; h < 320; h++) begin drive(h, 51, 16'(h), 1'b0); tick(); end
    frame_done_in = 1'b1; tick();
    quiet(2);
    check("busy_wait_sof", longint'(busy_out), 0);

    // Full raster frame; frame_done coincides with the last pixel.
    for (int v = 0; v < 240; v++) begin
      for (int h = 0; h < 320; h++) begin
        drive(h, v, 16'((v * 320 + h) * 7 + 3), 1'b1);
        if (v == 239 && h == 319) done_push(1'b0);
        tick();
        if (v == 0 && h == 0) check("busy_after_sof", longint'(busy_out), 1);
      end
    end
    quiet(2);
    drain();
    check("full_last_addr", longint'(addr_out), longint'(exp_addr(319, 239)));
    check("full_short", longint'(short_frame_out), 0);
    quiet(2);

    // Short frame of 1000 pixels, separate frame_done.
    for (int i = 0; i < 1000; i++) begin drive(i % 320, i / 320, 16'(i ^ 16'hA5A5), 1'b1); tick(); end
    pixel_valid_in = 1'b0;
    done_push(1'b1); tick();
    quiet(5);
    check("short_sticky", longint'(short_frame_out), 1);
    check("busy_after_done", longint'(busy_out), 0);

    // Next frame clears short; out-of-range pixels dropped and not counted.
    drive(0, 0, 16'hBEEF, 1'b1); tick();
    check("short_cleared_on_sof", longint'(short_frame_out), 0);
    drive(1, 0, 16'h0001, 1'b1); tick();
    drive(2, 0, 16'h0002, 1'b1); tick();
    drive(320, 0, 16'hDEAD, 1'b0); tick();
    drive(5, 240, 16'hDEAD, 1'b0); tick();
    drive(511, 255, 16'hDEAD, 1'b0); tick();
    drive(3, 0, 16'h0003, 1'b1); tick();
    pixel_valid_in = 1'b0;
    check("busy_capture", longint'(busy_out), 1);
    done_push(1'b1); tick();
    quiet(3);

    // SOF inside CAPTURE: no commit pulse, short set, stays in CAPTURE.
    drive(0, 0, 16'h0100, 1'b1); tick();
    check("short_clear_resof", longint'(short_frame_out), 0);
    drive(1, 0, 16'h0101, 1'b1); tick();
    drive(2, 0, 16'h0102, 1'b1); tick();
    drive(0, 0, 16'h0200, 1'b1); tick();
    check("short_on_restart", longint'(short_frame_out), 1);
    check("busy_on_restart", longint'(busy_out), 1);
    drive(1, 0, 16'h0201, 1'b1); tick();
    pixel_valid_in = 1'b0;
    done_push(1'b1); tick();
    quiet(3);

    // Directed corner addresses with hand-computed values.
`ifdef FB_ROTATE_EN
    drive_at(0, 0, 16'hC000, 239); tick();
    drive_at(319, 239, 16'hC001, 76560); tick();
    drive_at(5, 10, 16'hC002, 1429); tick();
`else
    drive_at(0, 0, 16'hC000, 0); tick();
    drive_at(319, 239, 16'hC001, 76799); tick();
    drive_at(5, 10, 16'hC002, 3205); tick();
`endif
    pixel_valid_in = 1'b0;
    done_push(1'b1); tick();
    quiet(2);
    drain();
    quiet(3);

    // Reset with two writes in flight: both dropped, outputs zero, nothing afterwards.
    drive(0, 0, 16'h7777, 1'b0); tick();
    drive(1, 0, 16'h8888, 1'b0); tick();
    rst_n_in       = 1'b0;
    pixel_valid_in = 1'b0;
    capture_en_in  = 1'b0;
    #1;
    check("midrst_addr", longint'(addr_out), 0);
    check("midrst_pix", longint'(pixel_out), 0);
    check("midrst_we", longint'(we_out), 0);
    check("midrst_short", longint'(short_frame_out), 0);
    check("midrst_busy", longint'(busy_out), 0);
    check("midrst_frame_valid", longint'(frame_valid_out), 0);
    tick(); tick();
    rst_n_in = 1'b1;
    quiet(10);
    check("post_rst_we", longint'(we_out), 0);
    check("post_rst_addr", longint'(addr_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
